// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters decoded into syncs, blanking, coordinates, map address and strobes.
// Latency: all outputs registered, one clock behind the counter state they decode, mutually aligned.
// Backpressure: none; the raster free-runs, and reset restarts it at (0,0).
module vga_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   SCALE_SHIFT = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        horiz_sync,
    output logic        vert_sync,
    output logic        video_on,
    output logic [10:0] pixel_column,
    output logic [10:0] pixel_row,
    output logic [13:0] world_addr,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        vis;
    logic        hs_act;
    logic        vs_act;

    // vcnt only moves on the last column, so h-wrap and v-wrap land on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 11'd0 : vcnt + 11'd1;
        end else begin
            hcnt <= hcnt + 11'd1;
        end
    end

    assign vis    = (hcnt < H_VIS) && (vcnt < V_VIS);
    assign hs_act = (hcnt >= HS_BEG) && (hcnt <= HS_END);
    assign vs_act = (vcnt >= VS_BEG) && (vcnt <= VS_END);

    // Decoding the current counters into one register stage keeps every output on the same pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            horiz_sync   <= ~SYNC_POL;
            vert_sync    <= ~SYNC_POL;
            video_on     <= 1'b0;
            pixel_column <= '0;
            pixel_row    <= '0;
            world_addr   <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            horiz_sync   <= hs_act ? SYNC_POL : ~SYNC_POL;
            vert_sync    <= vs_act ? SYNC_POL : ~SYNC_POL;
            video_on     <= vis;
            pixel_column <= hcnt;
            pixel_row    <= vcnt;
            world_addr   <= vis ? {7'(vcnt >> SCALE_SHIFT), 7'(hcnt >> SCALE_SHIFT)} : 14'd0;
            line_start   <= (hcnt == 11'd0);
            frame_start  <= (hcnt == 11'd0) && (vcnt == 11'd0);
        end
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Produces the raster timing that feeds the display colorizer.
- Free-running horizontal and vertical counters generate the HSYNC/VSYNC pulses, the `video_on` blanking qualifier, and the current pixel row/column.
- Also outputs a 14-bit world-map address, scaled down from the pixel coordinate, for the map/icon lookups; frame-start and line-start strobes pace the robot and icon logic.
- All outputs are registered and mutually aligned, so the colorizer and the VGA pins see a consistent pixel.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in clocks.
- `H_SYNC`, default 96: HSYNC pulse width, in clocks.
- `H_BP`, default 48: horizontal back porch, in clocks.
- `V_ACTIVE`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: VSYNC pulse width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.
- `SYNC_POL`, default 0: asserted level of both sync outputs (0 = active-low).
- `SCALE_SHIFT`, default 2: right-shift applied to row and column to form the world address.

Ports:
- `clock`, in, 1: pixel clock (25 MHz for the default timing); the only clock.
- `reset`, in, 1: asynchronous, active-high.
- `horiz_sync`, out, 1: HSYNC.
- `vert_sync`, out, 1: VSYNC.
- `video_on`, out, 1: high inside the active region.
- `pixel_column`, out, 11: current column.
- `pixel_row`, out, 11: current row.
- `world_addr`, out, 14: `{row>>SCALE_SHIFT [6:0], col>>SCALE_SHIFT [6:0]}`.
- `line_start`, out, 1: one-clock pulse on column 0 of each line.
- `frame_start`, out, 1: one-clock pulse on row 0, column 0.

## Operation
Derived totals:
- `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` = 800.
- `V_TOTAL` = 525.

Counters:
- `hcnt` runs 0..H_TOTAL-1 and wraps to 0.
- `vcnt` increments only on the clock where `hcnt == H_TOTAL-1`. It wraps to 0 when it is also at V_TOTAL-1.
- Simultaneous h-wrap and v-wrap is a single event: both counters go to 0 on that clock.

Registered outputs are decoded from the counter values. Regions, inclusive, at default timing:
- Horizontal visible: 0..639.
- HSYNC asserted: `H_ACTIVE+H_FP` .. `H_ACTIVE+H_FP+H_SYNC-1` = 656..751.
- Vertical visible: 0..479.
- VSYNC asserted: 490..491, for whole lines, aligned to `hcnt` = 0.

Output decode:
- `video_on` = hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- `pixel_column`/`pixel_row` carry `hcnt`/`vcnt` in every region, blanking included. Consumers must qualify them with `video_on`.
- `world_addr` is forced to 0 while `video_on` would be 0. Otherwise it is the shifted coordinate with 7 bits per axis; higher bits are truncated.
- `line_start` = (hcnt == 0). `frame_start` = (hcnt == 0 and vcnt == 0).

Reset behaviour:
- The counters clear to 0.
- Outputs take these values: sync outputs = ~SYNC_POL (inactive), and `video_on`, `pixel_row`, `pixel_column`, `world_addr`, `line_start`, `frame_start` all 0.
- A reset asserted mid-frame takes effect immediately and restarts the raster at (0,0). No partial sync pulse is extended after reset.

## Timing
- Latency: 1 clock. Outputs on cycle n+1 reflect the counter state at cycle n. All outputs share that latency, so there is no skew between sync, `video_on` and coordinates.
- After reset deasserts, the first clock edge loads the outputs for (0,0): `video_on`=1, `line_start`=1, `frame_start`=1, `world_addr`=0.
- Line period is H_TOTAL clocks; frame period is H_TOTAL*V_TOTAL = 420000 clocks.
- Strobe widths:
  - `frame_start` is high for exactly 1 clock per frame.
  - `line_start` is high for 1 clock per line, V_TOTAL times per frame, blanking lines included.
- HSYNC is asserted for exactly H_SYNC clocks per line on every line, including vertical blanking.
- VSYNC is asserted for exactly V_SYNC*H_TOTAL clocks.

## Test plan
- **Reset:** hold `reset` for 5 clocks, then release → during reset the syncs are 1, all other outputs 0. On the first edge after release, `frame_start`=1, `video_on`=1, and `pixel_row`=`pixel_column`=0.
- **Horizontal line:** check one full line → `video_on` high for 640 clocks. `horiz_sync` is low from `pixel_column` 656 through 751, i.e. 96 clocks. `line_start` pulses again 800 clocks later.
- **Frame period:** run 2 frames → the `frame_start` pulses are exactly 420000 clocks apart. `vert_sync` is low for 1600 clocks, starting when `pixel_row`=490 and `pixel_column`=0.
- **Wrap boundary:** at `pixel_column`=799, `pixel_row`=524, the next clock gives (0,0) and `frame_start`=1. The row never reads 525.
- **World address:** at row 479, col 639 → `world_addr` = {7'd119, 7'd159 truncated to 7'd31} = 14'h3B9F. At row 0, col 700 (blanking) → `world_addr` = 0 and `video_on` = 0.
- **Mid-frame reset:** assert `reset` at row 300, col 400 → outputs go to their reset values asynchronously, without waiting for a clock edge. The raster restarts at (0,0), and `frame_start` pulses on the first edge after release.
